// File: rtl/coin_accumulator_if.sv
// coin_accumulator_if: coin sensor lines, vend/refund controls and deposit outputs.
interface coin_accumulator_if;
  logic nickel_i, dime_i, quarter_i, cancel_i, vend_done_i;
  logic [5:0] deposit_o, refund_amt_o;
  logic coin_reject_o, refund_o, busy_o;
  modport master(output nickel_i, dime_i, quarter_i, cancel_i, vend_done_i,
                 input deposit_o, refund_amt_o, coin_reject_o, refund_o, busy_o);
  modport slave(input nickel_i, dime_i, quarter_i, cancel_i, vend_done_i,
                output deposit_o, refund_amt_o, coin_reject_o, refund_o, busy_o);
endinterface

// File: rtl/coin_accumulator.sv
// coin_accumulator: synchronises coin sensors and keeps the deposit total until vend, cancel or timeout.
module coin_accumulator #(
  parameter int unsigned PRICE = 20,
  parameter int unsigned TIMEOUT_CYC = 1000
) (
  input logic clk_i,
  input logic rst_i,
  coin_accumulator_if.slave bus
);
  typedef enum logic [1:0] {IDLE, COLLECT, VEND_WAIT, REFUND} state_t;
  localparam int CW = $clog2(TIMEOUT_CYC);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYC - 1);
  localparam logic [5:0] P = 6'(PRICE);
  state_t state;
  logic [2:0] s1, s2, prev, ev;
  logic [CW-1:0] cnt;
  logic multi, accept;
  logic [5:0] coin, sum;
  assign ev = s2 & ~prev;
  assign multi = (ev[0] & ev[1]) | (ev[0] & ev[2]) | (ev[1] & ev[2]);
  assign coin = ev[2] ? 6'd25 : ev[1] ? 6'd10 : 6'd5;
  assign sum = bus.deposit_o + coin;
  // cancel wins over a same-cycle coin in COLLECT; in IDLE cancel is meaningless
  assign accept = |ev && !multi && (state == IDLE || (state == COLLECT && !bus.cancel_i));
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= IDLE;
      s1 <= '0;
      s2 <= '0;
      prev <= '0;
      cnt <= '0;
      bus.deposit_o <= '0;
      bus.refund_amt_o <= '0;
      bus.coin_reject_o <= 1'b0;
      bus.refund_o <= 1'b0;
      bus.busy_o <= 1'b0;
    end else begin
      s1 <= {bus.quarter_i, bus.dime_i, bus.nickel_i};
      s2 <= s1;
      prev <= s2;
      bus.coin_reject_o <= |ev && !accept;
      bus.refund_o <= 1'b0;
      bus.refund_amt_o <= '0;
      case (state)
        IDLE: if (accept) begin
          bus.deposit_o <= coin;
          cnt <= '0;
          state <= coin >= P ? VEND_WAIT : COLLECT;
          bus.busy_o <= coin >= P;
        end
        COLLECT: if (bus.cancel_i || (!accept && cnt == LAST)) begin
          state <= REFUND;
          bus.refund_o <= 1'b1;
          bus.refund_amt_o <= bus.deposit_o;
          bus.deposit_o <= '0;
          bus.busy_o <= 1'b1;
          cnt <= '0;
        end else if (accept) begin
          bus.deposit_o <= sum;
          cnt <= '0;
          state <= sum >= P ? VEND_WAIT : COLLECT;
          bus.busy_o <= sum >= P;
        end else begin
          cnt <= cnt + 1'b1;
        end
        VEND_WAIT: if (bus.vend_done_i) begin
          bus.deposit_o <= '0;
          state <= IDLE;
          bus.busy_o <= 1'b0;
        end
        default: begin
          state <= IDLE;
          bus.busy_o <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_coin_accumulator.sv
// tb_coin_accumulator: randomized scoreboard bench against a transaction-level vending model.
module tb_coin_accumulator;
  localparam int PRICE = 20;
  localparam int TO = 16;
  typedef struct packed {logic [5:0] dep; logic rej; logic rfd; logic [5:0] amt; logic busy;} obs_t;
  logic clk_i = 0;
  logic rst_i = 1;
  always #5 clk_i = ~clk_i;
  coin_accumulator_if bus();
  coin_accumulator #(.PRICE(PRICE), .TIMEOUT_CYC(TO)) dut(.clk_i(clk_i), .rst_i(rst_i), .bus(bus));
  obs_t exp_q[$];
  obs_t o, e;
  logic [5:0] last = 0;
  int checks = 0, errors = 0;
  int total = 0, mode = 0;
  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual %0d required %0d at %0t", name, act, req, $time);
    end
  endtask
  function automatic void push(input logic [5:0] d, input logic rj, input logic rf, input logic [5:0] a, input logic b);
    exp_q.push_back('{d, rj, rf, a, b});
  endfunction
  initial begin
    forever begin
      @(negedge clk_i);
      if (rst_i) last = 0;
      else begin
        chk("refund_amt_quiet", bus.refund_o ? 0 : int'(bus.refund_amt_o), 0);
        if (bus.deposit_o != last || bus.coin_reject_o || bus.refund_o) begin
          o = '{bus.deposit_o, bus.coin_reject_o, bus.refund_o, bus.refund_amt_o, bus.busy_o};
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_output dep %0d rej %0b refund %0b amt %0d busy %0b at %0t",
                     o.dep, o.rej, o.rfd, o.amt, o.busy, $time);
          end else begin
            e = exp_q.pop_front();
            chk("deposit", o.dep, e.dep);
            chk("coin_reject", o.rej, e.rej);
            chk("refund", o.rfd, e.rfd);
            chk("refund_amt", o.amt, e.amt);
            chk("busy", o.busy, e.busy);
          end
          last = bus.deposit_o;
        end
      end
    end
  end
  initial begin
    #500000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end
  task automatic lines(input logic [2:0] mask, input int hold);
    @(posedge clk_i) #1 {bus.quarter_i, bus.dime_i, bus.nickel_i} = mask;
    repeat (hold) @(posedge clk_i);
    #1 {bus.quarter_i, bus.dime_i, bus.nickel_i} = 3'b000;
    repeat (4) @(posedge clk_i);
  endtask
  task automatic coin(input int which);
    int v;
    v = which == 0 ? 5 : which == 1 ? 10 : 25;
    if (mode == 2) push(6'(total), 1, 0, 0, 1);
    else begin
      total += v;
      mode = total >= PRICE ? 2 : 1;
      push(6'(total), 0, 0, 0, mode == 2);
    end
    lines(3'b001 << which, $urandom_range(1, 3));
  endtask
  task automatic double_coin(input logic [2:0] mask);
    push(6'(total), 1, 0, 0, mode == 2);
    lines(mask, $urandom_range(1, 3));
  endtask
  task automatic cancel();
    if (mode == 1) begin
      push(0, 0, 1, 6'(total), 1);
      total = 0;
      mode = 0;
    end
    @(posedge clk_i) #1 bus.cancel_i = 1;
    @(posedge clk_i) #1 bus.cancel_i = 0;
    repeat (3) @(posedge clk_i);
  endtask
  task automatic cancel_with_nickel();
    push(0, 1, 1, 6'(total), 1);
    total = 0;
    mode = 0;
    @(posedge clk_i) #1 bus.nickel_i = 1;
    repeat (2) @(posedge clk_i);
    #1 bus.cancel_i = 1;
    @(posedge clk_i) #1 bus.cancel_i = 0;
    bus.nickel_i = 0;
    repeat (4) @(posedge clk_i);
  endtask
  task automatic vend();
    if (mode == 2) begin
      push(0, 0, 0, 0, 0);
      total = 0;
      mode = 0;
    end
    @(posedge clk_i) #1 bus.vend_done_i = 1;
    repeat (2) @(posedge clk_i);
    #1 bus.vend_done_i = 0;
    repeat (3) @(posedge clk_i);
  endtask
  task automatic timeout();
    push(0, 0, 1, 6'(total), 1);
    total = 0;
    mode = 0;
    repeat (24) @(posedge clk_i);
  endtask
  task automatic check_quiet(input string tag);
    chk({tag, "_deposit"}, bus.deposit_o, 0);
    chk({tag, "_busy"}, bus.busy_o, 0);
    chk({tag, "_refund"}, bus.refund_o, 0);
    chk({tag, "_reject"}, bus.coin_reject_o, 0);
    chk({tag, "_amt"}, bus.refund_amt_o, 0);
  endtask
  initial begin
    int n, r;
    {bus.quarter_i, bus.dime_i, bus.nickel_i, bus.cancel_i, bus.vend_done_i} = '0;
    repeat (3) @(posedge clk_i);
    #1 check_quiet("reset");
    @(negedge clk_i) #1 rst_i = 0;
    coin(0);
    coin(1);
    @(posedge clk_i) #3 rst_i = 1;
    #1 check_quiet("async_reset");
    total = 0;
    mode = 0;
    repeat (2) @(negedge clk_i);
    #1 rst_i = 0;
    coin(0); coin(1); coin(0); vend();
    coin(1); coin(2); coin(0); vend();
    double_coin(3'b011);
    coin(1); cancel_with_nickel();
    push(5, 0, 0, 0, 0);
    push(0, 0, 1, 5, 1);
    total = 0;
    @(posedge clk_i) #1 bus.nickel_i = 1;
    n = 0;
    while (bus.deposit_o != 5 && n < 20) begin
      @(negedge clk_i);
      n++;
    end
    chk("coin_latency", n, 4);
    bus.nickel_i = 0;
    n = 0;
    while (!bus.refund_o && n < 40) begin
      @(negedge clk_i);
      n++;
    end
    chk("timeout_edges", n, TO);
    repeat (3) @(posedge clk_i);
    cancel();
    for (int i = 0; i < 80; i++) begin
      r = $urandom_range(0, 9);
      case (mode)
        0: if (r < 5) coin($urandom_range(0, 2));
           else if (r < 7) double_coin(r == 5 ? 3'b110 : 3'b101);
           else if (r < 9) cancel();
           else vend();
        1: if (r < 6) coin($urandom_range(0, 2));
           else if (r == 6) cancel();
           else if (r == 7) cancel_with_nickel();
           else if (r == 8) timeout();
           else coin(0);
        default: if (r < 3) coin($urandom_range(0, 2));
           else if (r == 3) double_coin(3'b111);
           else if (r == 4) cancel();
           else vend();
      endcase
    end
    if (mode == 1) cancel();
    if (mode == 2) vend();
    repeat (10) @(posedge clk_i);
    chk("queue_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
